// File: rtl/switch_debounce.sv
// switch_debounce: synchronises a raw switch input, qualifies level changes
// over STABLE_CNT consecutive i_tick samples, and emits a clean level plus
// single-cycle rise/fall pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   STABLE_LO | accepted level is 0, waiting for the synchronised input to go 1
//   CHK_HI    | input is 1, counting ticks before accepting the 0->1 change
//   STABLE_HI | accepted level is 1, waiting for the synchronised input to go 0
//   CHK_LO    | input is 0, counting ticks before accepting the 1->0 change
module switch_debounce #(
  parameter int   SYNC_STAGES = 2,
  parameter int   STABLE_CNT  = 16,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_sw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("switch_debounce: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CNT < 1) begin : g_bad_stable_cnt
    $error("switch_debounce: STABLE_CNT must be >= 1");
  end

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  state_t                 state;
  logic [CW-1:0]          cnt;

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous switch input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_sw};
    end
  end

  // Qualification FSM with registered level, edge pulses and busy flag.
  // A bounce back to the accepted level wins over a tick in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RESET_STATE;
      cnt     <= '0;
      o_level <= RESET_LEVEL;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (s_sync) begin
            state  <= CHK_HI;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end
        CHK_HI: begin
          if (!s_sync) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            o_busy <= 1'b0;
          end else if (i_tick) begin
            if (cnt == CNT_LAST) begin
              state   <= STABLE_HI;
              cnt     <= '0;
              o_level <= 1'b1;
              o_rise  <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        STABLE_HI: begin
          if (!s_sync) begin
            state  <= CHK_LO;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end
        CHK_LO: begin
          if (s_sync) begin
            state  <= STABLE_HI;
            cnt    <= '0;
            o_busy <= 1'b0;
          end else if (i_tick) begin
            if (cnt == CNT_LAST) begin
              state   <= STABLE_LO;
              cnt     <= '0;
              o_level <= 1'b0;
              o_fall  <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state   <= RESET_STATE;
          cnt     <= '0;
          o_level <= RESET_LEVEL;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce: three instances (default, STABLE_CNT=4,
// STABLE_CNT=1 with reset level 1 and three sync stages).
module tb_switch_debounce;

  logic clk = 1'b0;
  logic rst;
  logic sw_a, tick_a, sw_b, tick_b, sw_c, tick_c;
  logic level_a, rise_a, fall_a, busy_a;
  logic level_b, rise_b, fall_b, busy_b;
  logic level_c, rise_c, fall_c, busy_c;

  int n_tests = 0;
  int n_fail  = 0;
  int rise_cnt_a = 0, rise_cnt_b = 0, fall_cnt_b = 0, busy_cnt_b = 0;
  int fall_cnt_c = 0, both_cnt = 0;

  always #5 clk = ~clk;

  switch_debounce u_dut_a (
    .clk(clk), .rst(rst), .i_tick(tick_a), .i_sw(sw_a),
    .o_level(level_a), .o_rise(rise_a), .o_fall(fall_a), .o_busy(busy_a)
  );

  switch_debounce #(.SYNC_STAGES(2), .STABLE_CNT(4), .RESET_LEVEL(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .i_tick(tick_b), .i_sw(sw_b),
    .o_level(level_b), .o_rise(rise_b), .o_fall(fall_b), .o_busy(busy_b)
  );

  switch_debounce #(.SYNC_STAGES(3), .STABLE_CNT(1), .RESET_LEVEL(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .i_tick(tick_c), .i_sw(sw_c),
    .o_level(level_c), .o_rise(rise_c), .o_fall(fall_c), .o_busy(busy_c)
  );

  // Pulse and busy tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (rise_a) rise_cnt_a++;
    if (rise_b) rise_cnt_b++;
    if (fall_b) fall_cnt_b++;
    if (busy_b) busy_cnt_b++;
    if (fall_c) fall_cnt_c++;
    if ((rise_a && fall_a) || (rise_b && fall_b) || (rise_c && fall_c)) both_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int r0, f0, b0, hi;

  initial begin
    rst = 1'b0;
    sw_a = 1'b1; tick_a = 1'b1;
    sw_b = 1'b0; tick_b = 1'b1;
    sw_c = 1'b1; tick_c = 1'b1;
    repeat (3) step();

    // Reset values while rst is held, even though sw_a is already high.
    chk("rst_level_a", int'(level_a), 0);
    chk("rst_rise_a",  int'(rise_a), 0);
    chk("rst_fall_a",  int'(fall_a), 0);
    chk("rst_busy_a",  int'(busy_a), 0);
    chk("rst_level_b", int'(level_b), 0);
    chk("rst_level_c", int'(level_c), 1);

    // Post-reset mismatch on default instance: 2+1+16 = 19 edges.
    rst = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 18) chk("rel_level_18", int'(level_a), 0);
      if (k == 19) begin
        chk("rel_level_19", int'(level_a), 1);
        chk("rel_rise_19",  int'(rise_a), 1);
      end
      if (k == 20) chk("rel_rise_20", int'(rise_a), 0);
    end
    chk("rel_rise_count", rise_cnt_a, 1);
    chk("rel_level_c_hold", int'(level_c), 1);

    // Clean press on STABLE_CNT=4: level at edge 7, busy for edges 3..6.
    sw_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("press_level_%0d", k), int'(level_b), int'(k >= 7));
      chk($sformatf("press_busy_%0d", k),  int'(busy_b),  int'(k >= 3 && k <= 6));
      chk($sformatf("press_rise_%0d", k),  int'(rise_b),  int'(k == 7));
    end

    // STABLE_CNT=1, three sync stages: release accepted on edge 3+1+1 = 5.
    sw_c = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("cnt1_level_%0d", k), int'(level_c), int'(k < 5));
      chk($sformatf("cnt1_fall_%0d", k),  int'(fall_c),  int'(k == 5));
    end
    chk("cnt1_fall_count", fall_cnt_c, 1);

    // Tick gating: ticks on edges 10,20,30,40; CHK_LO entered at edge 3.
    f0 = fall_cnt_b;
    sw_b = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      tick_b = (k % 10 == 0);
      step();
      if (k == 39) begin
        chk("gate_level_39", int'(level_b), 1);
        chk("gate_busy_39",  int'(busy_b), 1);
        chk("gate_early",    fall_cnt_b - f0, 0);
      end
      if (k == 40) begin
        chk("gate_fall_40",  int'(fall_b), 1);
        chk("gate_level_40", int'(level_b), 0);
      end
    end
    chk("gate_fall_count", fall_cnt_b - f0, 1);

    // Bounce rejection: 3 high / 3 low for 30 cycles, tick always high.
    tick_b = 1'b1;
    r0 = rise_cnt_b; f0 = fall_cnt_b; b0 = busy_cnt_b; hi = 0;
    for (int k = 1; k <= 40; k++) begin
      sw_b = (k <= 30) && (((k - 1) / 3) % 2 == 0);
      step();
      if (level_b) hi++;
    end
    chk("bnc_level_high", hi, 0);
    chk("bnc_rise", rise_cnt_b - r0, 0);
    chk("bnc_fall", fall_cnt_b - f0, 0);
    chk("bnc_busy_seen", int'(busy_cnt_b > b0), 1);

    // Bounce in a tick gap: 2 ticks counted, abort at edge 24, full restart.
    r0 = rise_cnt_b;
    for (int k = 1; k <= 61; k++) begin
      tick_b = (k % 10 == 0);
      sw_b   = !(k >= 22 && k < 25);
      step();
      if (k == 23) chk("gap_busy_23", int'(busy_b), 1);
      if (k == 24) chk("gap_busy_24", int'(busy_b), 0);
      if (k == 59) begin
        chk("gap_level_59", int'(level_b), 0);
        chk("gap_rise_early", rise_cnt_b - r0, 0);
      end
      if (k == 60) begin
        chk("gap_level_60", int'(level_b), 1);
        chk("gap_rise_60",  int'(rise_b), 1);
      end
    end

    // Release back to 0 with tick high: 7 edges.
    tick_b = 1'b1;
    sw_b = 1'b0;
    repeat (8) step();
    chk("rel_b_level", int'(level_b), 0);

    // Reset mid-qualification: CHK_HI with cnt=3 after edge 6.
    sw_b = 1'b1;
    repeat (6) step();
    chk("mrst_busy_before", int'(busy_b), 1);
    r0 = rise_cnt_b;
    #2 rst = 1'b0;
    #1;
    chk("mrst_busy_b",  int'(busy_b), 0);
    chk("mrst_level_b", int'(level_b), 0);
    chk("mrst_level_a", int'(level_a), 0);
    chk("mrst_level_c", int'(level_c), 1);
    sw_b = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (30) step();
    chk("mrst_no_rise", rise_cnt_b - r0, 0);
    chk("mrst_level_after", int'(level_b), 0);

    chk("rise_fall_together", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
